// File: rtl/register_file_param_if.sv
// Bus bundle for register_file_param: one write port, two read ports,
// soft-clear request and sweep status.
//
// Handshake semantics: there is no valid/ready pair. A write is offered
// whenever write_en_1 is high at a rising clock edge and is accepted only if
// busy is low, clear is low and the address is in range; a rejected write is
// dropped, never held or retried. clear is a one-cycle request, sampled only
// while busy is low. Read addresses are sampled every edge and their data
// appears on read_port_x/read_valid_x after that edge.
interface register_file_param_if #(
  parameter int WIDTH  = 16,
  parameter int ADDR_W = 3
);
  logic [WIDTH-1:0]  write_port_1;
  logic [ADDR_W-1:0] write_addr_1;
  logic              write_en_1;
  logic [ADDR_W-1:0] read_addr_1;
  logic [ADDR_W-1:0] read_addr_2;
  logic              clear;
  logic [WIDTH-1:0]  read_port_1;
  logic [WIDTH-1:0]  read_port_2;
  logic              read_valid_1;
  logic              read_valid_2;
  logic              busy;
  logic              sweep_state;  // debug view of the soft-clear FSM (0 idle, 1 sweep)

  modport master (
    output write_port_1, write_addr_1, write_en_1, read_addr_1, read_addr_2, clear,
    input  read_port_1, read_port_2, read_valid_1, read_valid_2, busy, sweep_state
  );

  modport slave (
    input  write_port_1, write_addr_1, write_en_1, read_addr_1, read_addr_2, clear,
    output read_port_1, read_port_2, read_valid_1, read_valid_2, busy, sweep_state
  );
endinterface

// File: rtl/register_file_param.sv
// Parametrised register file: DEPTH x WIDTH storage with per-entry valid bits,
// one write port, two registered read ports, optional write-to-read bypass,
// optional hardwired-zero entry 0 and a one-entry-per-cycle soft-clear sweep.
module register_file_param #(
  parameter int WIDTH    = 16,
  parameter int DEPTH    = 8,
  parameter int BYPASS   = 1,
  parameter int ZERO_REG = 0
) (
  input  logic                 clk,
  input  logic                 reset,
  register_file_param_if.slave bus
);
  localparam int                ADDR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0]   DEPTH_EXT = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST_PTR  = ADDR_W'(DEPTH - 1);

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_SWEEP = 1'b1
  } state_t;

  state_t            state;
  state_t            state_next;
  logic [ADDR_W-1:0] ptr;
  logic [ADDR_W-1:0] ptr_next;

  logic [WIDTH-1:0]  mem [DEPTH];
  logic [DEPTH-1:0]  valid;

  logic              wr_accept;
  logic [WIDTH-1:0]  rd1_data;
  logic              rd1_valid;
  logic [WIDTH-1:0]  rd2_data;
  logic              rd2_valid;

  // DEPTH need not be a power of two, so some encodable addresses are holes.
  function automatic logic in_range(input logic [ADDR_W-1:0] a);
    return ({1'b0, a} < DEPTH_EXT);
  endfunction

  // A write lands only when idle, not pre-empted by clear, in range and not
  // aimed at a hardwired-zero entry.
  always_comb begin
    wr_accept = bus.write_en_1 && (state == S_IDLE) && !bus.clear &&
                in_range(bus.write_addr_1) &&
                !((ZERO_REG != 0) && (bus.write_addr_1 == '0));
  end

  // Soft-clear sequencer: next state and sweep pointer.
  always_comb begin
    state_next = state;
    ptr_next   = ptr;
    case (state)
      S_IDLE: begin
        if (bus.clear) begin
          state_next = S_SWEEP;
          ptr_next   = '0;
        end
      end
      S_SWEEP: begin
        if (ptr == LAST_PTR) begin
          state_next = S_IDLE;
          ptr_next   = '0;
        end else begin
          ptr_next = ptr + 1'b1;
        end
      end
      default: begin
        state_next = S_IDLE;
        ptr_next   = '0;
      end
    endcase
  end

  // Soft-clear sequencer state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
      ptr   <= '0;
    end else begin
      state <= state_next;
      ptr   <= ptr_next;
    end
  end

  assign bus.busy        = (state == S_SWEEP);
  assign bus.sweep_state = state;

  // Storage update: the sweep owns the array while busy, otherwise accepted writes.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
      valid <= '0;
    end else if (state == S_SWEEP) begin
      mem[ptr]   <= '0;
      valid[ptr] <= 1'b0;
    end else if (wr_accept) begin
      mem[bus.write_addr_1]   <= bus.write_port_1;
      valid[bus.write_addr_1] <= 1'b1;
    end
  end

  // Port 1 read mux: holes read as empty, zero entry reads as valid zero,
  // bypass forwards a same-cycle accepted write.
  always_comb begin
    rd1_data  = '0;
    rd1_valid = 1'b0;
    if (in_range(bus.read_addr_1)) begin
      if ((ZERO_REG != 0) && (bus.read_addr_1 == '0)) begin
        rd1_valid = 1'b1;
      end else if ((BYPASS != 0) && wr_accept && (bus.write_addr_1 == bus.read_addr_1)) begin
        rd1_data  = bus.write_port_1;
        rd1_valid = 1'b1;
      end else begin
        rd1_data  = mem[bus.read_addr_1];
        rd1_valid = valid[bus.read_addr_1];
      end
    end
  end

  // Port 2 read mux, independent of port 1.
  always_comb begin
    rd2_data  = '0;
    rd2_valid = 1'b0;
    if (in_range(bus.read_addr_2)) begin
      if ((ZERO_REG != 0) && (bus.read_addr_2 == '0)) begin
        rd2_valid = 1'b1;
      end else if ((BYPASS != 0) && wr_accept && (bus.write_addr_1 == bus.read_addr_2)) begin
        rd2_data  = bus.write_port_1;
        rd2_valid = 1'b1;
      end else begin
        rd2_data  = mem[bus.read_addr_2];
        rd2_valid = valid[bus.read_addr_2];
      end
    end
  end

  // Read output registers, one cycle after the address is presented.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bus.read_port_1  <= '0;
      bus.read_port_2  <= '0;
      bus.read_valid_1 <= 1'b0;
      bus.read_valid_2 <= 1'b0;
    end else begin
      bus.read_port_1  <= rd1_data;
      bus.read_port_2  <= rd2_data;
      bus.read_valid_1 <= rd1_valid;
      bus.read_valid_2 <= rd2_valid;
    end
  end
endmodule

// File: tb/tb_register_file_param.sv
// Bench for register_file_param. Four instances share one stimulus stream:
//   u0 default (DEPTH 8, bypass), u1 no bypass, u2 hardwired zero entry,
//   u3 DEPTH 6 (addresses 6 and 7 are holes).
// Expectations are queued with the cycle they apply to; a negedge monitor
// compares every expectation due in the current cycle.
module tb_register_file_param;
  localparam int EW = 16 + 5 + 16;  // {cycle tag, instance*5+field, value}

  logic        clk = 1'b0;
  logic        reset;
  logic        we;
  logic [2:0]  wa;
  logic [15:0] wd;
  logic [2:0]  ra1;
  logic [2:0]  ra2;
  logic        clr;

  int cyc      = 0;
  int n_checks = 0;
  int n_fail   = 0;

  logic [EW-1:0]    exp_q[$];
  wire [16*20-1:0]  act_flat;

  // Reference model state for the randomised phase.
  logic [15:0] m_mem  [4][8];
  logic        m_val  [4][8];
  logic        m_busy [4];
  int          m_ptr  [4];

  // ---------------- clock / reset block ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- DUT instances ----------------
  for (genvar g = 0; g < 4; g++) begin : g_dut
    localparam int P_DEPTH = (g == 3) ? 6 : 8;
    localparam int P_BYP   = (g == 1) ? 0 : 1;
    localparam int P_ZR    = (g == 2) ? 1 : 0;

    register_file_param_if #(.WIDTH(16), .ADDR_W(3)) bus ();

    register_file_param #(
      .WIDTH(16), .DEPTH(P_DEPTH), .BYPASS(P_BYP), .ZERO_REG(P_ZR)
    ) u_dut (
      .clk  (clk),
      .reset(reset),
      .bus  (bus)
    );

    assign bus.write_port_1 = wd;
    assign bus.write_addr_1 = wa;
    assign bus.write_en_1   = we;
    assign bus.read_addr_1  = ra1;
    assign bus.read_addr_2  = ra2;
    assign bus.clear        = clr;

    assign act_flat[(g*5+0)*16 +: 16] = bus.read_port_1;
    assign act_flat[(g*5+1)*16 +: 16] = {15'b0, bus.read_valid_1};
    assign act_flat[(g*5+2)*16 +: 16] = bus.read_port_2;
    assign act_flat[(g*5+3)*16 +: 16] = {15'b0, bus.read_valid_2};
    assign act_flat[(g*5+4)*16 +: 16] = {15'b0, bus.busy};
  end

  function automatic string fname(input int f);
    case (f)
      0:       return "read_port_1";
      1:       return "read_valid_1";
      2:       return "read_port_2";
      3:       return "read_valid_2";
      default: return "busy";
    endcase
  endfunction

  function automatic int dep(input int i);
    return (i == 3) ? 6 : 8;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic expect_tag(input int tag, input int inst, input int field, input logic [15:0] val);
    exp_q.push_back({16'(tag), 5'(inst * 5 + field), val});
  endtask

  task automatic expect_next(input int inst, input int field, input logic [15:0] val);
    expect_tag(cyc + 1, inst, field, val);
  endtask

  task automatic expect_rd(input int inst, input logic [15:0] d1, input logic v1,
                           input logic [15:0] d2, input logic v2);
    expect_next(inst, 0, d1);
    expect_next(inst, 1, {15'b0, v1});
    expect_next(inst, 2, d2);
    expect_next(inst, 3, {15'b0, v2});
  endtask

  task automatic drive(input logic w_en, input logic [2:0] w_addr, input logic [15:0] w_data,
                       input logic [2:0] r1, input logic [2:0] r2, input logic c);
    we  = w_en;
    wa  = w_addr;
    wd  = w_data;
    ra1 = r1;
    ra2 = r2;
    clr = c;
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      for (int a = 0; a < 8; a++) begin
        m_mem[i][a] = 16'd0;
        m_val[i][a] = 1'b0;
      end
      m_busy[i] = 1'b0;
      m_ptr[i]  = 0;
    end
  endtask

  function automatic logic [16:0] model_read(input int i, input logic [2:0] ra, input logic acc);
    if (int'(ra) >= dep(i)) return 17'd0;
    if (i == 2 && ra == 3'd0) return {1'b1, 16'd0};
    if (i != 1 && acc && wa == ra) return {1'b1, wd};
    return {m_val[i][ra], m_mem[i][ra]};
  endfunction

  // Predict the outputs after the coming edge from current inputs, then advance.
  task automatic model_step();
    for (int i = 0; i < 4; i++) begin
      logic        acc;
      logic [16:0] r1;
      logic [16:0] r2;
      acc = we && !m_busy[i] && !clr && (int'(wa) < dep(i)) && !(i == 2 && wa == 3'd0);
      r1  = model_read(i, ra1, acc);
      r2  = model_read(i, ra2, acc);
      expect_rd(i, r1[15:0], r1[16], r2[15:0], r2[16]);
      if (m_busy[i]) begin
        m_mem[i][m_ptr[i]] = 16'd0;
        m_val[i][m_ptr[i]] = 1'b0;
        if (m_ptr[i] == dep(i) - 1) begin
          m_busy[i] = 1'b0;
          m_ptr[i]  = 0;
        end else begin
          m_ptr[i] = m_ptr[i] + 1;
        end
      end else if (clr) begin
        m_busy[i] = 1'b1;
        m_ptr[i]  = 0;
      end else if (acc) begin
        m_mem[i][wa] = wd;
        m_val[i][wa] = 1'b1;
      end
      expect_next(i, 4, {15'b0, m_busy[i]});
    end
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin : monitor
    int            k;
    int            idx;
    logic [EW-1:0] e;
    logic [15:0]   act;
    k = 0;
    while (k < exp_q.size()) begin
      e   = exp_q[k];
      idx = int'(e[20:16]);
      if (e[EW-1 -: 16] == 16'(cyc)) begin
        act = act_flat[idx*16 +: 16];
        n_checks++;
        if (act !== e[15:0]) begin
          n_fail++;
          $display("FAIL u%0d.%s cyc=%0d actual=%h expected=%h",
                   idx / 5, fname(idx % 5), cyc, act, e[15:0]);
        end
        exp_q.delete(k);
      end else if (e[EW-1 -: 16] < 16'(cyc)) begin
        n_checks++;
        n_fail++;
        $display("FAIL u%0d.%s stale expectation tag=%0d cyc=%0d",
                 idx / 5, fname(idx % 5), e[EW-1 -: 16], cyc);
        exp_q.delete(k);
      end else begin
        k++;
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin : stim
    int n;
    int m;
    reset = 1'b1;
    we = 1'b0; wa = '0; wd = '0; ra1 = '0; ra2 = '0; clr = 1'b0;

    // Reset state
    for (int f = 0; f < 5; f++) expect_tag(1, 0, f, 16'd0);
    expect_tag(1, 2, 1, 16'd0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;

    // Basic writes and reads
    expect_next(0, 1, 16'd0);
    expect_next(2, 0, 16'd0);
    expect_next(2, 1, 16'd1);
    drive(1'b1, 3'd1, 16'd65, 3'd0, 3'd0, 1'b0);
    expect_rd(0, 16'd65, 1'b1, 16'd241, 1'b1);
    expect_rd(1, 16'd65, 1'b1, 16'd0, 1'b0);
    drive(1'b1, 3'd2, 16'd241, 3'd1, 3'd2, 1'b0);
    for (int i = 0; i < 4; i++) expect_rd(i, 16'd65, 1'b1, 16'd241, 1'b1);
    drive(1'b0, 3'd0, 16'd0, 3'd1, 3'd2, 1'b0);
    expect_rd(0, 16'd0, 1'b0, 16'd0, 1'b0);
    expect_rd(3, 16'd0, 1'b0, 16'd0, 1'b0);
    drive(1'b0, 3'd0, 16'd0, 3'd3, 3'd3, 1'b0);

    // Bypass on both ports vs. no bypass
    expect_rd(0, 16'd73, 1'b1, 16'd73, 1'b1);
    expect_rd(1, 16'd0, 1'b0, 16'd0, 1'b0);
    drive(1'b1, 3'd4, 16'd73, 3'd4, 3'd4, 1'b0);
    expect_rd(1, 16'd73, 1'b1, 16'd73, 1'b1);
    drive(1'b0, 3'd0, 16'd0, 3'd4, 3'd4, 1'b0);

    // Hardwired zero entry
    expect_rd(0, 16'd93, 1'b1, 16'd93, 1'b1);
    expect_rd(1, 16'd0, 1'b0, 16'd0, 1'b0);
    expect_rd(2, 16'd0, 1'b1, 16'd0, 1'b1);
    drive(1'b1, 3'd0, 16'd93, 3'd0, 3'd0, 1'b0);
    expect_rd(0, 16'd93, 1'b1, 16'd256, 1'b1);
    expect_rd(2, 16'd0, 1'b1, 16'd256, 1'b1);
    drive(1'b1, 3'd5, 16'd256, 3'd0, 3'd5, 1'b0);
    expect_rd(1, 16'd93, 1'b1, 16'd256, 1'b1);
    expect_rd(2, 16'd0, 1'b1, 16'd256, 1'b1);
    drive(1'b0, 3'd0, 16'd0, 3'd0, 3'd5, 1'b0);

    // Out-of-range addresses on the DEPTH 6 instance
    expect_rd(0, 16'h1234, 1'b1, 16'd0, 1'b0);
    expect_rd(3, 16'd0, 1'b0, 16'd0, 1'b0);
    drive(1'b1, 3'd6, 16'h1234, 3'd6, 3'd7, 1'b0);
    expect_rd(0, 16'h1234, 1'b1, 16'h1234, 1'b1);
    expect_rd(3, 16'd0, 1'b0, 16'd0, 1'b0);
    drive(1'b0, 3'd0, 16'd0, 3'd6, 3'd6, 1'b0);

    // Fill every entry, then soft clear with a blocked write and a repeat clear
    for (int a = 0; a < 8; a++) drive(1'b1, 3'(a), 16'h0100 + 16'(a), 3'd0, 3'd0, 1'b0);
    n = cyc + 1;
    for (int k = 0; k <= 8; k++) begin
      expect_tag(n + k, 0, 4, (k < 8) ? 16'd1 : 16'd0);
      expect_tag(n + k, 3, 4, (k < 6) ? 16'd1 : 16'd0);
    end
    expect_rd(0, 16'h0103, 1'b1, 16'h0107, 1'b1);
    drive(1'b1, 3'd3, 16'd123, 3'd3, 3'd7, 1'b1);
    drive(1'b1, 3'd3, 16'd123, 3'd3, 3'd7, 1'b0);
    drive(1'b0, 3'd0, 16'd0, 3'd0, 3'd0, 1'b1);
    drive(1'b0, 3'd0, 16'd0, 3'd0, 3'd0, 1'b0);
    expect_rd(0, 16'd0, 1'b0, 16'h0105, 1'b1);
    expect_rd(3, 16'd0, 1'b0, 16'h0105, 1'b1);
    drive(1'b0, 3'd0, 16'd0, 3'd1, 3'd5, 1'b0);
    repeat (4) drive(1'b0, 3'd0, 16'd0, 3'd0, 3'd0, 1'b0);
    expect_rd(0, 16'd0, 1'b0, 16'd0, 1'b0);
    expect_rd(1, 16'd0, 1'b0, 16'd0, 1'b0);
    drive(1'b1, 3'd2, 16'h0abc, 3'd3, 3'd7, 1'b0);
    expect_rd(0, 16'h0abc, 1'b1, 16'd0, 1'b0);
    expect_rd(1, 16'h0abc, 1'b1, 16'd0, 1'b0);
    drive(1'b0, 3'd0, 16'd0, 3'd2, 3'd7, 1'b0);

    // Asynchronous reset in the middle of a sweep
    drive(1'b1, 3'd7, 16'h0055, 3'd7, 3'd7, 1'b0);
    m = cyc + 1;
    expect_tag(m, 0, 4, 16'd1);
    expect_rd(0, 16'h0055, 1'b1, 16'h0055, 1'b1);
    drive(1'b0, 3'd0, 16'd0, 3'd7, 3'd7, 1'b1);
    repeat (3) drive(1'b0, 3'd0, 16'd0, 3'd7, 3'd7, 1'b0);
    #1;
    reset = 1'b1;
    for (int f = 0; f < 5; f++) expect_tag(cyc, 0, f, 16'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    expect_rd(0, 16'd0, 1'b0, 16'd0, 1'b0);
    expect_next(0, 4, 16'd0);
    drive(1'b1, 3'd6, 16'd198, 3'd7, 3'd7, 1'b0);
    expect_rd(0, 16'd198, 1'b1, 16'd198, 1'b1);
    expect_rd(3, 16'd0, 1'b0, 16'd0, 1'b0);
    drive(1'b0, 3'd0, 16'd0, 3'd6, 3'd6, 1'b0);

    // Randomised traffic against the reference model
    @(negedge clk);
    #1;
    reset = 1'b1;
    model_reset();
    @(posedge clk);
    #1;
    reset = 1'b0;
    for (int t = 0; t < 200; t++) begin
      we  = 1'($urandom_range(0, 1));
      wa  = 3'($urandom_range(0, 7));
      wd  = 16'($urandom_range(0, 65535));
      ra1 = 3'($urandom_range(0, 7));
      ra2 = 3'($urandom_range(0, 7));
      clr = ($urandom_range(0, 15) == 0);
      model_step();
      @(posedge clk);
      #1;
    end
    we  = 1'b0;
    clr = 1'b0;

    // ---------------- final report ----------------
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    while (exp_q.size() > 0) begin
      logic [EW-1:0] e;
      e = exp_q.pop_front();
      n_checks++;
      n_fail++;
      $display("FAIL u%0d.%s never checked tag=%0d",
               int'(e[20:16]) / 5, fname(int'(e[20:16]) % 5), e[EW-1 -: 16]);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
